// File: rtl/alu_result_serializer.sv
// ---------------------------------------------------------------------------
// alu_result_serializer
// Captures a registered ALU/compare result on its alu_valid strobe and
// streams it to the UART TX front-end as DATA_WIDTH-bit words, LSB word
// first, over a valid/ready handshake.
//
// Narrow results (res_wide=0) send the low word only. Wide results send all
// NUM_WORDS = RES_WIDTH/DATA_WIDTH words.
//
// Optional feature, selected by the macro SER_CHECKSUM_EN:
//   When defined, each burst ends with one extra word holding the XOR of all
//   result words sent in that burst.
//   When undefined, bursts carry result words only.
// ---------------------------------------------------------------------------
module alu_result_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int RES_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RES_WIDTH-1:0]  alu_out,
   input  logic                  alu_valid,
   input  logic                  res_wide,
   input  logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  busy,
   output logic                  overrun
);

   localparam int NUM_WORDS = RES_WIDTH / DATA_WIDTH;
   localparam int CNT_W     = $clog2(NUM_WORDS + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_WORDS);

   // Reject configurations where the result bus is not a whole number of words.
   if ((RES_WIDTH % DATA_WIDTH) != 0 || RES_WIDTH < DATA_WIDTH) begin : g_bad_cfg
      $error("alu_result_serializer: RES_WIDTH must be a multiple of DATA_WIDTH");
   end

`ifdef SER_CHECKSUM_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      CKSUM = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1
   } state_t;
`endif

   state_t                 state_q;
   state_t                 state_d;
   logic [RES_WIDTH-1:0]   shift_reg;
   logic [CNT_W-1:0]       words_left;
   logic [CNT_W-1:0]       load_cnt;
   logic                   capture;
   logic                   last_xfer;
   logic                   word_xfer;
   logic                   drop;
`ifdef SER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]  cksum_reg;
`endif

   // A narrow result always sends one word; so does any result when it fits in one word.
   assign load_cnt = (res_wide && (NUM_WORDS > 1)) ? CNT_FULL : CNT_ONE;

   // An incoming result is dropped whenever the block is busy and cannot hand over this cycle.
   assign drop = alu_valid && busy && !last_xfer;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode, handshake outputs and capture/transfer strobes.
   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = '0;
      capture   = 1'b0;
      last_xfer = 1'b0;
      word_xfer = 1'b0;
      case (state_q)
         IDLE: begin
            if (alu_valid) begin
               capture = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_data  = shift_reg[DATA_WIDTH-1:0];
            if (tx_ready) begin
               word_xfer = 1'b1;
               if (words_left == CNT_ONE) begin
`ifdef SER_CHECKSUM_EN
                  // The checksum word follows; the burst is not over yet.
                  state_d = CKSUM;
`else
                  last_xfer = 1'b1;
                  state_d   = IDLE;
                  if (alu_valid) begin
                     capture = 1'b1;
                     state_d = SEND;
                  end
`endif
               end
            end
         end
`ifdef SER_CHECKSUM_EN
         CKSUM: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_data  = cksum_reg;
            if (tx_ready) begin
               last_xfer = 1'b1;
               state_d   = IDLE;
               if (alu_valid) begin
                  capture = 1'b1;
                  state_d = SEND;
               end
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Capture register, word counter and overrun pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg  <= '0;
         words_left <= '0;
         overrun    <= 1'b0;
      end else begin
         overrun <= drop;
         if (capture) begin
            shift_reg  <= alu_out;
            words_left <= load_cnt;
         end else if (word_xfer) begin
            shift_reg <= shift_reg >> DATA_WIDTH;
            if (words_left != '0) begin
               words_left <= words_left - CNT_ONE;
            end
         end
      end
   end

`ifdef SER_CHECKSUM_EN
   // Running XOR of the result words sent in the current burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cksum_reg <= '0;
      end else if (capture) begin
         cksum_reg <= '0;
      end else if (word_xfer) begin
         cksum_reg <= cksum_reg ^ shift_reg[DATA_WIDTH-1:0];
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_alu_result_serializer
// Directed bench for alu_result_serializer (DATA_WIDTH=8, RES_WIDTH=16).
// Expected words are pushed to a scoreboard queue when a result is driven
// and popped by a monitor on every accepted transfer.
// ---------------------------------------------------------------------------
module tb_alu_result_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] alu_out;
   logic        alu_valid;
   logic        res_wide;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic        overrun;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  sb[$];
   int          burst_len;
   int          cycles;

`ifdef SER_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   alu_result_serializer #(.DATA_WIDTH(8), .RES_WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_out   (alu_out),
      .alu_valid (alu_valid),
      .res_wide  (res_wide),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Monitor: a word moves on the edge following a mid-cycle valid&ready.
   always @(negedge clk) begin
      if (!rst && tx_valid && tx_ready) begin
         n_checks++;
         assert (sb.size() != 0) n_pass++;
         else $error("FAIL unexpected_word: observed %0h expected none", tx_data);
         if (sb.size() != 0) begin
            logic [7:0] e;
            e = sb.pop_front();
            chk("stream_word", {24'd0, tx_data}, {24'd0, e});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push the expected word stream for one result; burst_len gets its length.
   task automatic push_result(input logic [15:0] v, input logic wide);
      logic [7:0]  x;
      logic [15:0] t;
      int          n;
      n = wide ? 2 : 1;
      x = 8'h00;
      t = v;
      for (int i = 0; i < n; i++) begin
         sb.push_back(t[7:0]);
         x = x ^ t[7:0];
         t = t >> 8;
      end
      if (CK == 1) sb.push_back(x);
      burst_len = n + CK;
   endtask

   // Drive a one-cycle result strobe; returns just after the capture edge.
   task automatic send(input logic [15:0] v, input logic wide, input logic expect_push);
      alu_out   = v;
      res_wide  = wide;
      alu_valid = 1'b1;
      if (expect_push) push_result(v, wide);
      tick();
      alu_valid = 1'b0;
      alu_out   = 16'h0000;
      res_wide  = 1'b0;
   endtask

   // Wait (bounded) for busy to fall; cnt is the number of edges it took.
   task automatic wait_idle(input string tag, output int cnt);
      cnt = 0;
      while (busy && cnt < 50) begin
         tick();
         cnt++;
      end
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      alu_out   = 16'h0000;
      alu_valid = 1'b0;
      res_wide  = 1'b0;
      tx_ready  = 1'b0;
      #2;
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_busy",     {31'd0, busy},     32'd0);
      chk("rst_tx_data",  {24'd0, tx_data},  32'd0);
      chk("rst_overrun",  {31'd0, overrun},  32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Narrow result: one word (plus checksum) right after capture.
      tx_ready = 1'b1;
      send(16'h0003, 1'b0, 1'b1);
      chk("narrow_valid", {31'd0, tx_valid}, 32'd1);
      chk("narrow_data",  {24'd0, tx_data},  32'h03);
      chk("narrow_busy",  {31'd0, busy},     32'd1);
      wait_idle("narrow", cycles);
      chk("narrow_cycles", cycles, burst_len);
      chk("narrow_sb_empty", sb.size(), 32'd0);
      tick();

      // Wide result: both words on consecutive cycles.
      send(16'hA55A, 1'b1, 1'b1);
      chk("wide_first", {24'd0, tx_data}, 32'h5A);
      tick();
      chk("wide_second", {24'd0, tx_data}, 32'hA5);
      chk("wide_valid2", {31'd0, tx_valid}, 32'd1);
      wait_idle("wide", cycles);
      chk("wide_cycles", cycles + 1, burst_len);
      chk("wide_sb_empty", sb.size(), 32'd0);
      tick();

      // Backpressure: word 0 held stable while tx_ready is low.
      tx_ready = 1'b0;
      send(16'h1234, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", {31'd0, tx_valid}, 32'd1);
         chk("bp_data",  {24'd0, tx_data},  32'h34);
         tick();
      end
      tx_ready = 1'b1;
      wait_idle("bp", cycles);
      chk("bp_sb_empty", sb.size(), 32'd0);
      tick();

      // Overrun: a result arriving mid-burst is dropped with a one-cycle pulse.
      tx_ready = 1'b0;
      send(16'h1234, 1'b1, 1'b1);
      tick();
      send(16'hFFFF, 1'b1, 1'b0);
      chk("ovr_pulse", {31'd0, overrun}, 32'd1);
      chk("ovr_data_held", {24'd0, tx_data}, 32'h34);
      tick();
      chk("ovr_pulse_end", {31'd0, overrun}, 32'd0);
      tx_ready = 1'b1;
      wait_idle("ovr", cycles);
      chk("ovr_sb_empty", sb.size(), 32'd0);
      tick();

      // Back-to-back: new result coincident with the final transfer.
      send(16'hBEEF, 1'b1, 1'b1);
      tick();
      if (CK == 1) tick();
      send(16'h00C1, 1'b0, 1'b1);
      chk("b2b_overrun", {31'd0, overrun},  32'd0);
      chk("b2b_busy",    {31'd0, busy},     32'd1);
      chk("b2b_valid",   {31'd0, tx_valid}, 32'd1);
      chk("b2b_data",    {24'd0, tx_data},  32'hC1);
      wait_idle("b2b", cycles);
      chk("b2b_sb_empty", sb.size(), 32'd0);
      tick();

      // Asynchronous reset mid-burst, between clock edges.
      tx_ready = 1'b0;
      send(16'h1234, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("arst_busy",     {31'd0, busy},     32'd0);
      chk("arst_tx_data",  {24'd0, tx_data},  32'd0);
      sb.delete();
      tx_ready = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_valid", {31'd0, tx_valid}, 32'd0);
         chk("post_rst_busy",  {31'd0, busy},     32'd0);
      end

      // Fresh result after reset proceeds normally.
      send(16'h5566, 1'b1, 1'b1);
      chk("after_rst_data", {24'd0, tx_data}, 32'h66);
      wait_idle("after_rst", cycles);
      tick();
      chk("final_sb_empty", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Consumer end of the ALU result interface: captures a registered ALU/compare result on its valid pulse and streams it as DATA_WIDTH-bit words, LSB word first, to the UART TX path over a valid/ready handshake.
- Sits between the ALU output register and the UART TX front-end, inside the system-control datapath.
- Narrow results such as compare codes and flags send one word; wide results such as multiply send all words.

Parameters:
- DATA_WIDTH, 8, width of one transmitted word.
- RES_WIDTH, 16, width of the ALU result bus. Must be an integer multiple of DATA_WIDTH, at least DATA_WIDTH. NUM_WORDS = RES_WIDTH/DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_out  input  RES_WIDTH  ALU result, valid only when alu_valid=1.
- alu_valid  input  1  single-cycle result strobe.
- res_wide  input  1  sampled with alu_valid: 1 sends NUM_WORDS words, 0 sends the low word only.
- tx_ready  input  1  UART TX can accept a word this cycle.
- tx_data  output  DATA_WIDTH  word presented to UART TX.
- tx_valid  output  1  tx_data is valid.
- busy  output  1  a result is held and not yet fully sent.
- overrun  output  1  one-cycle pulse when an incoming result is dropped.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, all outputs 0 (tx_data, tx_valid, busy, overrun), word index 0, capture register 0.
- Reset mid-transfer aborts the transfer; the partially sent result is discarded and nothing resumes after reset release.
- Transfer rule: one word moves on a rising edge where tx_valid=1 and tx_ready=1.
- While tx_valid=1 and tx_ready=0, tx_data is held stable. tx_valid never drops without a transfer.
- States:
  - IDLE: busy=0, tx_valid=0. If alu_valid=1: capture alu_out into shift_reg; set words_left = NUM_WORDS if res_wide=1, else 1; go to SEND.
  - SEND: busy=1, tx_valid=1, tx_data = shift_reg[DATA_WIDTH-1:0]. On each transfer, shift shift_reg right by DATA_WIDTH and decrement words_left. On the transfer where words_left=1, go to IDLE (or to CKSUM when the optional feature is enabled).
- Latency: alu_valid at edge N gives tx_valid=1 with word 0 after edge N (visible in cycle N+1). Minimum burst time is words_sent cycles when tx_ready is held at 1.
- Back-to-back: if alu_valid=1 in the same cycle as the final transfer of a burst, the new result is captured and the block stays in SEND with no idle gap and no overrun.
- Overrun: if alu_valid=1 while busy=1 and the cycle is not the final-transfer cycle, the new result is ignored. overrun pulses 1 for exactly one cycle. The in-flight burst is unaffected.
- alu_out and res_wide are ignored when alu_valid=0. res_wide is ignored when NUM_WORDS=1.
- No arithmetic beyond the counter. words_left is ceil(log2(NUM_WORDS+1)) bits wide and never wraps below 0.

Optional Feature:
- Macro: SER_CHECKSUM_EN.
- When defined: after the last result word, state CKSUM presents one additional word, the XOR of all words sent in the burst (running XOR, cleared on capture), under the same handshake. Go to IDLE after it transfers. The back-to-back capture rule moves to the checksum-transfer cycle, and busy stays 1 through CKSUM.
- When undefined: no CKSUM state and no XOR register. Bursts carry result words only.

Test Plan:
- Narrow result: RES_WIDTH=16. Pulse alu_valid with alu_out=16'h0003, res_wide=0, tx_ready=1 -> exactly one word 8'h03 in the cycle after capture, then busy=0. With SER_CHECKSUM_EN, followed by 8'h03.
- Wide result: alu_out=16'hA55A, res_wide=1, tx_ready=1 -> words 8'h5A then 8'hA5 on consecutive cycles. With SER_CHECKSUM_EN, a third word 8'hFF.
- Backpressure: alu_out=16'h1234, res_wide=1, tx_ready low for 3 cycles after tx_valid rises -> tx_data holds 8'h34 and tx_valid stays 1 throughout, then 8'h34 and 8'h12 transfer once tx_ready=1.
- Overrun: during a stalled burst of 16'h1234, pulse alu_valid with 16'hFFFF -> overrun high exactly 1 cycle, output stream remains 8'h34, 8'h12, no 8'hFF.
- Back-to-back: second alu_valid (16'h00C1, res_wide=0) coincident with the final transfer of 16'hBEEF -> stream 8'hEF, 8'hBE, 8'hC1 with no idle cycle and overrun=0.
- Async reset: assert rst mid-burst between clock edges -> tx_valid, busy, tx_data go 0 immediately. After release, no residual words until the next alu_valid.
